// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream masters and its crossbar-facing port.
// master drives requests and write data; slave drives readies and responses.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter: one transaction in flight, grant held from grant cycle to R/B handshake.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with m[0] highest.
module axi_lite_arbiter #(
  parameter  int MASTER_NUM = 2,
  localparam int GRANT_W    = $clog2(MASTER_NUM)
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m [MASTER_NUM],
  axi_lite_if.master s
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [GRANT_W-1:0] winner;

  logic [MASTER_NUM-1:0] mArvalid, mRready, mAwvalid, mWvalid, mBready, reqVec;
  logic [31:0]           mAraddr [MASTER_NUM];
  logic [31:0]           mAwaddr [MASTER_NUM];
  logic [31:0]           mWdata  [MASTER_NUM];
  logic [3:0]            mWmask  [MASTER_NUM];

  logic [MASTER_NUM-1:0] arreadyVec, rvalidVec, awreadyVec, wreadyVec, bvalidVec;
  logic [31:0]           rdataVec [MASTER_NUM];
  logic [1:0]            rrespVec [MASTER_NUM];
  logic [1:0]            brespVec [MASTER_NUM];

  logic        sArvalid, sRready, sAwvalid, sWvalid, sBready;
  logic        sArready, sRvalid, sAwready, sWready, sBvalid;
  logic [31:0] sRdata;
  logic [1:0]  sRresp, sBresp;

  // Flatten the interface array so the grant index can select a master at run time.
  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_flat
    assign mArvalid[i] = m[i].arvalid;
    assign mAraddr[i]  = m[i].araddr;
    assign mRready[i]  = m[i].rready;
    assign mAwvalid[i] = m[i].awvalid;
    assign mAwaddr[i]  = m[i].awaddr;
    assign mWvalid[i]  = m[i].wvalid;
    assign mWdata[i]   = m[i].wdata;
    assign mWmask[i]   = m[i].wmask;
    assign mBready[i]  = m[i].bready;

    assign m[i].arready = arreadyVec[i];
    assign m[i].rvalid  = rvalidVec[i];
    assign m[i].rdata   = rdataVec[i];
    assign m[i].rresp   = rrespVec[i];
    assign m[i].awready = awreadyVec[i];
    assign m[i].wready  = wreadyVec[i];
    assign m[i].bvalid  = bvalidVec[i];
    assign m[i].bresp   = brespVec[i];
  end

  assign s.arvalid = sArvalid;
  assign s.araddr  = mAraddr[grant_q];
  assign s.rready  = sRready;
  assign s.awvalid = sAwvalid;
  assign s.awaddr  = mAwaddr[grant_q];
  assign s.wvalid  = sWvalid;
  assign s.wdata   = mWdata[grant_q];
  assign s.wmask   = mWmask[grant_q];
  assign s.bready  = sBready;

  assign sArready = s.arready;
  assign sRvalid  = s.rvalid;
  assign sRdata   = s.rdata;
  assign sRresp   = s.rresp;
  assign sAwready = s.awready;
  assign sWready  = s.wready;
  assign sBvalid  = s.bvalid;
  assign sBresp   = s.bresp;

  assign reqVec = mArvalid | mAwvalid;

`ifdef AXI_ARB_RR_EN
  int   rrIdx;
  logic found;

  // Search starts one past the last served master so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rrIdx  = 0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      rrIdx = (int'(last_q) + k) % MASTER_NUM;
      if (!found && reqVec[GRANT_W'(rrIdx)]) begin
        winner = GRANT_W'(rrIdx);
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (reqVec[GRANT_W'(i)]) winner = GRANT_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(MASTER_NUM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    sArvalid   = 1'b0;
    sRready    = 1'b0;
    sAwvalid   = 1'b0;
    sWvalid    = 1'b0;
    sBready    = 1'b0;
    arreadyVec = '0;
    rvalidVec  = '0;
    awreadyVec = '0;
    wreadyVec  = '0;
    bvalidVec  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      rdataVec[i] = '0;
      rrespVec[i] = '0;
      brespVec[i] = '0;
    end

    unique case (state_q)
      IDLE: begin
        // A read beats a write from the same master.
        if (|reqVec) begin
          grant_d = winner;
          state_d = mArvalid[winner] ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: begin
        sArvalid            = mArvalid[grant_q];
        arreadyVec[grant_q] = sArready;
        if (sArvalid && sArready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalidVec[grant_q] = sRvalid;
        rdataVec[grant_q]  = sRdata;
        rrespVec[grant_q]  = sRresp;
        sRready            = mRready[grant_q];
        if (sRvalid && sRready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        sAwvalid            = mAwvalid[grant_q];
        awreadyVec[grant_q] = sAwready;
        if (sAwvalid && sAwready) state_d = WR_DATA;
      end
      WR_DATA: begin
        sWvalid            = mWvalid[grant_q];
        wreadyVec[grant_q] = sWready;
        if (sWvalid && sWready) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalidVec[grant_q] = sBvalid;
        brespVec[grant_q]  = sBresp;
        sBready            = mBready[grant_q];
        if (sBvalid && sBready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Masking handshakes during reset keeps an abandoned transaction from completing.
    if (reset) begin
      sArvalid   = 1'b0;
      sRready    = 1'b0;
      sAwvalid   = 1'b0;
      sWvalid    = 1'b0;
      sBready    = 1'b0;
      arreadyVec = '0;
      rvalidVec  = '0;
      awreadyVec = '0;
      wreadyVec  = '0;
      bvalidVec  = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
        rdataVec[i] = '0;
        rrespVec[i] = '0;
        brespVec[i] = '0;
      end
    end
  end

endmodule
